// File: rtl/pattern_line_hflipper.sv
// Horizontal mirror for one packed pattern row on the tile fetch path.
// Provides a same-cycle combinational flipped row and a one-cycle registered
// copy qualified by out_valid, together with a per-pixel opacity mask where
// pixel code 0 is transparent. The mirror reverses whole pixel fields; the
// bit order inside each pixel is preserved.
module pattern_line_hflipper #(
  parameter int PIXELS = 8,
  parameter int BPP    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [PIXELS*BPP-1:0]   in_line,
  input  logic                    in_hflip,
  output logic [PIXELS*BPP-1:0]   comb_line,
  output logic                    out_valid,
  output logic [PIXELS*BPP-1:0]   out_line,
  output logic [PIXELS-1:0]       out_opaque
);

  localparam int W = PIXELS * BPP;

  // Reject geometries that make no sense for a pattern row.
  generate
    if (PIXELS < 1) begin : g_bad_pixels
      $error("pattern_line_hflipper: PIXELS must be at least 1");
    end
    if (BPP < 1) begin : g_bad_bpp
      $error("pattern_line_hflipper: BPP must be at least 1");
    end
  endgenerate

  logic [W-1:0]      mirrored_line;
  logic [W-1:0]      flipped_line;
  logic [PIXELS-1:0] flipped_mask;

  // Output pixel i takes input pixel PIXELS-1-i; pixel 0 lives in the MSBs.
  // With a single pixel this collapses to a straight wire.
  genvar gi;
  generate
    for (gi = 0; gi < PIXELS; gi++) begin : g_mirror
      assign mirrored_line[W-1-gi*BPP -: BPP] =
        in_line[W-1-(PIXELS-1-gi)*BPP -: BPP];
    end
  endgenerate

  // Select mirrored or untouched row; used both combinationally and for the register.
  always_comb begin
    flipped_line = in_line;
    if (in_hflip) begin
      flipped_line = mirrored_line;
    end
  end

  // Opacity is derived from the already-flipped row so it lines up with out_line.
  generate
    for (gi = 0; gi < PIXELS; gi++) begin : g_mask
      assign flipped_mask[PIXELS-1-gi] = |flipped_line[W-1-gi*BPP -: BPP];
    end
  endgenerate

  assign comb_line = flipped_line;

  logic              valid_q,  valid_d;
  logic [W-1:0]      line_q,   line_d;
  logic [PIXELS-1:0] opaque_q, opaque_d;

  // Capture a new row whenever one is offered; otherwise keep the last row and drop valid.
  always_comb begin
    valid_d  = 1'b0;
    line_d   = line_q;
    opaque_d = opaque_q;
    if (in_valid) begin
      valid_d  = 1'b1;
      line_d   = flipped_line;
      opaque_d = flipped_mask;
    end
  end

  // Output register; reset wins over any row presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      line_q   <= '0;
      opaque_q <= '0;
    end else begin
      valid_q  <= valid_d;
      line_q   <= line_d;
      opaque_q <= opaque_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_line   = line_q;
  assign out_opaque = opaque_q;

endmodule

// File: tb/tb_pattern_line_hflipper.sv
// Self-checking bench for pattern_line_hflipper: directed rows for the
// documented cases plus randomized traffic against a pixel-list model.
module tb_pattern_line_hflipper;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic [15:0] in_line;
  logic        in_hflip;
  logic [15:0] comb_line;
  logic        out_valid;
  logic [15:0] out_line;
  logic [7:0]  out_opaque;

  logic        p_valid;
  logic [11:0] p_line;
  logic        p_hflip;
  logic [11:0] p_comb;
  logic        p_out_valid;
  logic [11:0] p_out_line;
  logic [3:0]  p_out_opaque;

  int n_checks;
  int n_errors;

  pattern_line_hflipper #(.PIXELS(8), .BPP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_line    (in_line),
    .in_hflip   (in_hflip),
    .comb_line  (comb_line),
    .out_valid  (out_valid),
    .out_line   (out_line),
    .out_opaque (out_opaque)
  );

  pattern_line_hflipper #(.PIXELS(4), .BPP(3)) dut_p (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (p_valid),
    .in_line    (p_line),
    .in_hflip   (p_hflip),
    .comb_line  (p_comb),
    .out_valid  (p_out_valid),
    .out_line   (p_out_line),
    .out_opaque (p_out_opaque)
  );

  always #5 clk = ~clk;

  // Reference: split the row into a list of pixel codes, reverse the list, repack.
  function automatic logic [63:0] model_flip(input logic [63:0] line, input int px,
                                              input int bpp, input logic hflip);
    longint pix[$];
    logic [63:0] res;
    logic [63:0] fmask;
    fmask = (64'd1 << bpp) - 64'd1;
    for (int i = 0; i < px; i++) begin
      pix.push_back(longint'((line >> ((px - 1 - i) * bpp)) & fmask));
    end
    if (hflip) pix.reverse();
    res = '0;
    foreach (pix[i]) res = (res << bpp) | 64'(pix[i]);
    return res;
  endfunction

  // Reference: bit px-1-i is set when pixel i of the row is non-zero.
  function automatic logic [63:0] model_mask(input logic [63:0] line, input int px, input int bpp);
    logic [63:0] res;
    logic [63:0] fmask;
    fmask = (64'd1 << bpp) - 64'd1;
    res = '0;
    for (int i = 0; i < px; i++) begin
      if (((line >> ((px - 1 - i) * bpp)) & fmask) != 64'd0) res[px - 1 - i] = 1'b1;
    end
    return res;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_line = 16'hFFFF; in_hflip = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_valid got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_line !== 16'h0000) begin
      n_errors++; $display("[TB] FAIL reset_line got %h expected 0000", out_line);
    end
    n_checks++;
    if (out_opaque !== 8'h00) begin
      n_errors++; $display("[TB] FAIL reset_opaque got %h expected 00", out_opaque);
    end
    n_checks++;
    if (comb_line !== 16'hFFFF) begin
      n_errors++; $display("[TB] FAIL reset_comb got %h expected FFFF", comb_line);
    end
    n_checks++;
    if (p_out_valid !== 1'b0 || p_out_line !== 12'h000 || p_out_opaque !== 4'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_param got v=%b l=%h m=%h expected 0/000/0",
               p_out_valid, p_out_line, p_out_opaque);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_line = 16'h1231; in_hflip = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_line !== 16'h4C84) begin
      n_errors++;
      $display("[TB] FAIL post_reset_row got v=%b l=%h expected 1/4C84", out_valid, out_line);
    end
  endtask

  task automatic test_flip();
    @(negedge clk);
    in_valid = 1'b1; in_line = 16'h1231; in_hflip = 1'b1;
    #1;
    n_checks++;
    if (comb_line !== 16'h4C84) begin
      n_errors++; $display("[TB] FAIL flip_comb got %h expected 4C84", comb_line);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_line !== 16'h4C84 || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL flip_reg got v=%b l=%h expected 1/4C84", out_valid, out_line);
    end
    n_checks++;
    if (out_opaque !== 8'hAA) begin
      n_errors++; $display("[TB] FAIL flip_opaque got %h expected AA", out_opaque);
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    in_valid = 1'b1; in_line = 16'h1231; in_hflip = 1'b0;
    #1;
    n_checks++;
    if (comb_line !== 16'h1231) begin
      n_errors++; $display("[TB] FAIL pass_comb got %h expected 1231", comb_line);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_line !== 16'h1231 || out_opaque !== 8'h55) begin
      n_errors++;
      $display("[TB] FAIL pass_reg got l=%h m=%h expected 1231/55", out_line, out_opaque);
    end
    @(negedge clk);
    in_line = 16'h1BE4; in_hflip = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_line !== 16'h1BE4 || out_opaque !== 8'h7E) begin
      n_errors++;
      $display("[TB] FAIL symmetric_row got l=%h m=%h expected 1BE4/7E", out_line, out_opaque);
    end
  endtask

  task automatic test_valid_gating();
    @(negedge clk);
    in_valid = 1'b1; in_line = 16'hC000; in_hflip = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_line !== 16'h0003 || out_opaque !== 8'h01) begin
      n_errors++;
      $display("[TB] FAIL gate_load got v=%b l=%h m=%h expected 1/0003/01",
               out_valid, out_line, out_opaque);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_line = 16'h1234; in_hflip = k[0];
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_line !== 16'h0003 || out_opaque !== 8'h01) begin
        n_errors++;
        $display("[TB] FAIL gate_hold%0d got v=%b l=%h m=%h expected 0/0003/01",
                 k, out_valid, out_line, out_opaque);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_l;
    logic [63:0] exp_m;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_line = 16'($urandom()); in_hflip = k[0];
      exp_l = model_flip(64'(in_line), 8, 2, in_hflip);
      exp_m = model_mask(exp_l, 8, 2);
      #1;
      n_checks++;
      if (comb_line !== exp_l[15:0]) begin
        n_errors++;
        $display("[TB] FAIL b2b_comb%0d got %h expected %h", k, comb_line, exp_l[15:0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_line !== exp_l[15:0] || out_opaque !== exp_m[7:0]) begin
        n_errors++;
        $display("[TB] FAIL b2b_row%0d got v=%b l=%h m=%h expected 1/%h/%h",
                 k, out_valid, out_line, out_opaque, exp_l[15:0], exp_m[7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic        exp_v;
    logic [63:0] exp_l;
    logic [63:0] exp_m;
    logic [63:0] cur_l;
    exp_v = out_valid; exp_l = 64'(out_line); exp_m = 64'(out_opaque);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_line  = 16'($urandom());
      in_hflip = 1'($urandom_range(0, 1));
      cur_l = model_flip(64'(in_line), 8, 2, in_hflip);
      #1;
      n_checks++;
      if (comb_line !== cur_l[15:0]) begin
        n_errors++;
        $display("[TB] FAIL rand_comb%0d got %h expected %h", k, comb_line, cur_l[15:0]);
      end
      if (rst) begin
        exp_v = 1'b0; exp_l = '0; exp_m = '0;
      end else if (in_valid) begin
        exp_v = 1'b1; exp_l = cur_l; exp_m = model_mask(cur_l, 8, 2);
      end else begin
        exp_v = 1'b0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== exp_v || out_line !== exp_l[15:0] || out_opaque !== exp_m[7:0]) begin
        n_errors++;
        $display("[TB] FAIL rand_row%0d got v=%b l=%h m=%h expected %b/%h/%h",
                 k, out_valid, out_line, out_opaque, exp_v, exp_l[15:0], exp_m[7:0]);
      end
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_param();
    logic [63:0] exp_l;
    logic [63:0] exp_m;
    @(negedge clk);
    p_valid = 1'b1; p_line = 12'o1234; p_hflip = 1'b1;
    #1;
    n_checks++;
    if (p_comb !== 12'o4321) begin
      n_errors++; $display("[TB] FAIL param_comb got %o expected 4321", p_comb);
    end
    @(posedge clk); #1;
    n_checks++;
    if (p_out_valid !== 1'b1 || p_out_line !== 12'o4321 || p_out_opaque !== 4'hF) begin
      n_errors++;
      $display("[TB] FAIL param_row got v=%b l=%o m=%h expected 1/4321/F",
               p_out_valid, p_out_line, p_out_opaque);
    end
    @(negedge clk);
    p_line = 12'o0567; p_hflip = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (p_out_line !== 12'o7650 || p_out_opaque !== 4'hE) begin
      n_errors++;
      $display("[TB] FAIL param_zero_pixel got l=%o m=%h expected 7650/E", p_out_line, p_out_opaque);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      p_line = 12'($urandom()); p_hflip = k[0];
      exp_l = model_flip(64'(p_line), 4, 3, p_hflip);
      exp_m = model_mask(exp_l, 4, 3);
      @(posedge clk); #1;
      n_checks++;
      if (p_out_line !== exp_l[11:0] || p_out_opaque !== exp_m[3:0]) begin
        n_errors++;
        $display("[TB] FAIL param_rand%0d got l=%o m=%h expected %o/%h",
                 k, p_out_line, p_out_opaque, exp_l[11:0], exp_m[3:0]);
      end
    end
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clk = 1'b0; rst = 1'b0;
    in_valid = 1'b0; in_line = '0; in_hflip = 1'b0;
    p_valid = 1'b0; p_line = '0; p_hflip = 1'b0;
    n_checks = 0; n_errors = 0;
    test_reset();
    test_flip();
    test_passthrough();
    test_valid_gating();
    test_back_to_back();
    test_random();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_line_hflipper.md
Name: pattern_line_hflipper

Overview:
Horizontal mirror for one pattern row of packed multi-bit pixels, used by the background/foreground tile fetch path before scanline memory. Offers a combinational flipped result for same-cycle use. Also offers a one-cycle registered copy with valid qualification and a per-pixel opacity mask (pixel code 0 is transparent).

Parameters:
PIXELS, 8, pixels per pattern row (>=1)
BPP, 2, bits per pixel (>=1)

Ports:
clk  in  1  system clock (pixel clock domain)
rst  in  1  synchronous reset, active-high
in_valid  in  1  qualifies in_line/in_hflip this cycle
in_line  in  PIXELS*BPP  packed row; pixel 0 (leftmost) in MSBs [W-1 -: BPP], pixel PIXELS-1 in [BPP-1:0]
in_hflip  in  1  1 = mirror row horizontally, 0 = pass through
comb_line  out  PIXELS*BPP  combinational flipped row (no clock involvement)
out_valid  out  1  registered in_valid
out_line  out  PIXELS*BPP  registered flipped row
out_opaque  out  PIXELS  registered mask; bit PIXELS-1-i = 1 iff output pixel i != 0 (MSB = leftmost pixel)

Behaviour:
- W = PIXELS*BPP.
- Flip definition: with hflip=1, output pixel i = input pixel PIXELS-1-i. Each pixel's BPP-bit field keeps its internal bit order. This is a pixel-field reversal, not a bit reversal. With hflip=0, output equals input exactly.
- comb_line = flip(in_line, in_hflip). It is purely combinational and ignores in_valid and rst.
- Registered path, 1-cycle latency. On a rising clk edge:
  - If rst=1: out_valid<=0, out_line<=0, out_opaque<=0. rst has priority over in_valid.
  - Else if in_valid=1: out_valid<=1, out_line<=flip(in_line,in_hflip), out_opaque<=mask of that flipped row.
  - Else: out_valid<=0; out_line and out_opaque hold their previous values.
- Back-to-back: a new row can be accepted every cycle. There is no backpressure and no ready signal.
- Reset mid-stream: the row presented during the cycle rst is high is dropped. Outputs read 0 / invalid on the following cycle.
- Opacity is computed from the flipped row, so it is always aligned with out_line.
- PIXELS=1: flip is identity.
- Illegal parameter values (PIXELS<1 or BPP<1) shall be rejected at elaboration.

Test Plan:
1. Flip, default params: in_line=16'h1231 (00_01_00_10_00_11_00_01), hflip=1 -> comb_line=16'h4C84 in the same cycle. Next cycle: out_line=16'h4C84, out_valid=1, out_opaque=8'hAA. (A bit reversal would give 16'h8C48, which must not appear.)
2. Pass-through: in_line=16'h1231, hflip=0 -> comb_line=out_line=16'h1231, out_opaque=8'h55. Symmetric row 16'h1BE4 (00_01_10_11_11_10_01_00) with hflip=1 -> 16'h1BE4.
3. Reset: hold rst=1 with in_valid=1 and in_line=16'hFFFF -> after the edge, out_valid=0, out_line=0, out_opaque=0, while comb_line=16'hFFFF. Release rst -> next valid row appears one cycle later.
4. Valid gating: valid row 16'hC000 with hflip=1, then in_valid=0 with in_line=16'h1234 -> out_line=16'h0003 and out_opaque=8'h01, both held. out_valid goes 1 then 0.
5. Streaming: 8 consecutive valid rows with alternating hflip -> each output matches the flip of the input from exactly one cycle earlier, with no gaps.
6. Parameterised: PIXELS=4, BPP=3, in_line=12'o1234, hflip=1 -> out_line=12'o4321, out_opaque=4'hF. A zero pixel in position 0 clears mask bit 0 after the flip.
